adxl355_bus_arb: RTL

//  Owns the ADXL355 SPI bus. Sequences periodic reader-core transactions on each SYNC
//  (DRDY) pulse and shares the bus with ESP32 direct access (ctrl byte bit 1).

---
 rtl/adxl355_bus_arb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/adxl355_bus_arb.sv
// adxl355_bus_arb: owns the ADXL355 SPI bus. Starts one reader-core transaction
// per SYNC pulse, hands the bus to the ESP32 on request, switches the mux only
// while the bus is quiet, and counts SYNC pulses that could not be served.
module adxl355_bus_arb #(
    parameter int C_RD_TIMEOUT  = 4096,
    parameter int C_DIR_TIMEOUT = 2**26,
    parameter int C_GUARD       = 16,
    parameter int C_CNT_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_sync,
    input  logic                  i_direct_req,
    input  logic                  i_esp_csn,
    input  logic                  i_rd_busy,
    output logic                  o_rd_start,
    output logic                  o_direct_en,
    output logic [C_CNT_BITS-1:0] o_missed,
    output logic [C_CNT_BITS-1:0] o_rd_abort,
    output logic                  o_dir_to,
    output logic [1:0]            o_state
);

    localparam int RD_W  = $clog2(C_RD_TIMEOUT + 1);
    localparam int DIR_W = $clog2(C_DIR_TIMEOUT + 1);
    localparam int GRD_W = $clog2(C_GUARD + 1);

    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(C_RD_TIMEOUT - 1);
    localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(C_DIR_TIMEOUT - 1);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'(C_GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_DIRECT  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              csn_meta;
    logic              csn_s;
    logic              busy_seen;
    logic              dir_block;
    logic [RD_W-1:0]   rd_timer;
    logic [DIR_W-1:0]  dir_timer;
    logic [GRD_W-1:0]  grd_timer;
    logic              rd_to;
    logic              dir_hit;
    logic              missed_inc;

    assign o_state = state;

    // Two-flop synchronizer for the asynchronous ESP32 chip select.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value; blocking here would collapse the 2-FF chain.
        if (rst) begin
            csn_meta <= 1'b0;
            csn_s    <= 1'b0;
        end else begin
            csn_meta <= i_esp_csn;
            csn_s    <= csn_meta;
        end
    end

    // Next-state decode; bus ownership changes only when the ESP32 CSn is high.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves a signal unassigned and infers a latch.
        state_next = state;
        rd_to      = (state == S_READ)   && (rd_timer  == RD_LAST);
        dir_hit    = (state == S_DIRECT) && (dir_timer == DIR_LAST);
        missed_inc = i_sync && (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (i_sync)
                    state_next = S_READ;
                else if (i_direct_req && csn_s && !dir_block)
                    state_next = S_DIRECT;
            end
            S_READ: begin
                if ((busy_seen && !i_rd_busy) || rd_to)
                    state_next = S_IDLE;
            end
            S_DIRECT: begin
                if (csn_s && (!i_direct_req || dir_block))
                    state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (grd_timer == GRD_LAST)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus registered strobe and mux select derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            o_rd_start  <= 1'b0;
            o_direct_en <= 1'b0;
        end else begin
            state       <= state_next;
            o_rd_start  <= (state == S_IDLE) && (state_next == S_READ);
            o_direct_en <= (state_next == S_DIRECT);
        end
    end

    // Per-state timers; each restarts from zero whenever its state is left.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_timer  <= '0;
            dir_timer <= '0;
            grd_timer <= '0;
            busy_seen <= 1'b0;
        end else begin
            if (state == S_READ) begin
                rd_timer  <= rd_timer + 1'b1;
                busy_seen <= busy_seen | i_rd_busy;
            end else begin
                rd_timer  <= '0;
                busy_seen <= 1'b0;
            end
            if (state != S_DIRECT)
                dir_timer <= '0;
            else if (dir_timer != DIR_LAST)
                dir_timer <= dir_timer + 1'b1;
            if (state == S_RELEASE)
                grd_timer <= grd_timer + 1'b1;
            else
                grd_timer <= '0;
        end
    end

    // Direct-mode timeout flag (sticky) and re-entry block until request drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_dir_to  <= 1'b0;
            dir_block <= 1'b0;
        end else begin
            if (dir_hit)
                o_dir_to <= 1'b1;
            if (!i_direct_req)
                dir_block <= 1'b0;
            else if (dir_hit)
                dir_block <= 1'b1;
        end
    end

    // Saturating event counters for unserved SYNC pulses and reader aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_missed   <= '0;
            o_rd_abort <= '0;
        end else begin
            if (missed_inc && (o_missed != '1))
                o_missed <= o_missed + 1'b1;
            if (rd_to && (o_rd_abort != '1))
                o_rd_abort <= o_rd_abort + 1'b1;
        end
    end

endmodule
